// File: rtl/zia_walk_sequencer.sv
// zia_walk_sequencer: self-test sequencer for the ZIA wide-AND fabric.
// Drives an all-ones baseline, then walks a single zero across the input
// bus. Each step waits SETTLE cycles and then compares the observed outputs
// against the expected pattern. The run stops at the first mismatch and
// reports the failing step together with the captured outputs.
module zia_walk_sequencer #(
  parameter int unsigned      N_IN   = 39,
  parameter int unsigned      N_OUT  = 8,
  parameter int unsigned      SETTLE = 3,
  parameter logic [N_OUT-1:0] EXP_HI = N_OUT'(8'hFF),
  parameter logic [N_OUT-1:0] EXP_LO = N_OUT'(8'h00)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  drv,
  input  logic [N_OUT-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       fail_step,
  output logic [N_OUT-1:0] fail_obs
);

  localparam int unsigned CW        = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [5:0]    LAST_STEP = 6'(N_IN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t             state_q;
  logic [5:0]         step_q;
  logic [CW-1:0]      cnt_q;
  logic [N_IN-1:0]    drv_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [5:0]         fstep_q;
  logic [N_OUT-1:0]   fobs_q;

  logic [N_IN-1:0]    walk_d;
  logic [N_OUT-1:0]   exp_d;

  // Drive vector for the next step (zero at bit step_q) and the pattern
  // expected from the fabric during the current step.
  always_comb begin
    walk_d = ~(N_IN'(1) << step_q);
    exp_d  = (step_q == 6'd0) ? EXP_HI : EXP_LO;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      drv_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fstep_q <= '0;
      fobs_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          drv_q <= '1;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            step_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            fstep_q <= '0;
            fobs_q  <= '0;
          end
        end
        S_RUN: begin
          if (cnt_q == SETTLE_C) begin
            if (obs == exp_d) begin
              if (step_q == LAST_STEP) begin
                state_q <= S_FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
                drv_q   <= '1;
              end else begin
                // drv moves together with the step index so the new
                // vector is on the bus for the whole settle window
                step_q <= step_q + 6'd1;
                cnt_q  <= '0;
                drv_q  <= walk_d;
              end
            end else begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b0;
              fstep_q <= step_q;
              fobs_q  <= obs;
              drv_q   <= '1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          drv_q   <= '1;
        end
      endcase
    end
  end

  assign drv       = drv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fstep_q;
  assign fail_obs  = fobs_q;

endmodule

// File: tb/tb_zia_walk_sequencer.sv
// Testbench for zia_walk_sequencer: a behavioural fabric model feeds obs,
// expected run results are queued at start and compared at done.
module tb_zia_walk_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [38:0] drv;
  logic [7:0]  obs;
  logic        busy, done, pass;
  logic [5:0]  fail_step;
  logic [7:0]  fail_obs;

  logic        start_s;
  logic [3:0]  drv_s;
  logic [7:0]  obs_s;
  logic        busy_s, done_s, pass_s;
  logic [5:0]  fail_step_s;
  logic [7:0]  fail_obs_s;

  int n_chk = 0;
  int n_err = 0;

  // fabric fault mode: 0 golden, 1 bit 17 stuck-at-1, 2 obs forced to 8'hBF
  int          mode = 0;
  logic [7:0]  p1;

  typedef struct {
    bit         pass;
    int         step;
    logic [7:0] obs;
    int         cycles;
  } exp_t;
  exp_t exp_q[$];

  zia_walk_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .drv(drv), .obs(obs),
    .busy(busy), .done(done), .pass(pass),
    .fail_step(fail_step), .fail_obs(fail_obs)
  );

  zia_walk_sequencer #(.N_IN(4), .SETTLE(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .drv(drv_s), .obs(obs_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_step(fail_step_s), .fail_obs(fail_obs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fab(input logic [38:0] d, input int m);
    logic [38:0] v;
    v = d;
    if (m == 1) v[17] = 1'b1;
    if (m == 2) return 8'hBF;
    return (&v) ? 8'hFF : 8'h00;
  endfunction

  // main fabric: two register stages; small fabric: one stage (SETTLE=1)
  always @(posedge clk) begin
    p1    <= fab(drv, mode);
    obs   <= p1;
    obs_s <= (&drv_s) ? 8'hFF : 8'h00;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit p, input int s, input logic [7:0] o, input int c);
    exp_t e;
    e.pass = p; e.step = s; e.obs = o; e.cycles = c;
    exp_q.push_back(e);
  endtask

  // Follows a run already requested on start; returns at the done cycle.
  task automatic run_check(input bit repulse, input bit exp_first_pass_clear);
    int cyc = 0;
    int nb  = 0;
    bit seen = 0;
    bit first_pass = 1'b1;
    logic [38:0] drv_done = '0;
    bit busy_done = 1'b1;
    exp_t e;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 5 || cyc == 40);
      if (cyc == 1) first_pass = pass;
      if (busy) nb++;
      if (done) begin
        seen      = 1'b1;
        drv_done  = drv;
        busy_done = busy;
      end
    end
    start = 1'b0;
    chk("run_done_seen", 64'(seen), 64'd1);
    e = exp_q.pop_front();
    chk("run_busy_cycles", 64'(nb), 64'(e.cycles));
    chk("run_pass", 64'(pass), 64'(e.pass));
    chk("run_fail_step", 64'(fail_step), 64'(e.step));
    chk("run_fail_obs", 64'(fail_obs), 64'(e.obs));
    chk("run_drv_at_done", 64'(drv_done), 64'h7F_FFFF_FFFF);
    chk("run_busy_at_done", 64'(busy_done), 64'd0);
    if (exp_first_pass_clear) chk("pass_cleared_at_start", 64'(first_pass), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ndone;
    bit seen;
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (3) @(negedge clk);
    // start while in reset must do nothing
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_drv", 64'(drv), 64'h7F_FFFF_FFFF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail_step", 64'(fail_step), 64'd0);
    chk("rst_fail_obs", 64'(fail_obs), 64'd0);
    chk("rst_small_drv", 64'(drv_s), 64'hF);
    repeat (3) @(negedge clk);

    // golden run with start re-pulsed mid-run
    mode = 0;
    push_exp(1'b1, 0, 8'h00, 160);
    start = 1'b1;
    run_check(1'b1, 1'b0);

    // start during FIN ignored, start on the following cycle accepted
    start = 1'b1;
    @(negedge clk);
    chk("fin_start_ignored", 64'(busy), 64'd0);
    chk("pass_held_idle", 64'(pass), 64'd1);
    push_exp(1'b1, 0, 8'h00, 160);
    run_check(1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // bit 17 stuck-at-1 detected at step 18
    mode = 1;
    repeat (3) @(negedge clk);
    push_exp(1'b0, 18, 8'hFF, 76);
    start = 1'b1;
    run_check(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // baseline failure
    mode = 2;
    repeat (3) @(negedge clk);
    push_exp(1'b0, 0, 8'hBF, 4);
    start = 1'b1;
    run_check(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // reset mid-run
    mode = 0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("midrun_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_drv", 64'(drv), 64'h7F_FFFF_FFFF);
    chk("midrun_rst_done", 64'(done), 64'd0);
    chk("midrun_rst_fail_step", 64'(fail_step), 64'd0);
    ndone = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrun_no_done", 64'(ndone), 64'd0);

    // short configuration: N_IN=4, SETTLE=1
    nb = 0; seen = 1'b0;
    start_s = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (busy_s) nb++;
      if (done_s) seen = 1'b1;
    end
    start_s = 1'b0;
    chk("small_done_seen", 64'(seen), 64'd1);
    chk("small_busy_cycles", 64'(nb), 64'd10);
    chk("small_pass", 64'(pass_s), 64'd1);
    chk("small_fail_step", 64'(fail_step_s), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
